// File: rtl/sdr_ahb_pkg.sv
// sdr_ahb_pkg
// Shared definitions for the two-master AHB-Lite arbiter that fronts the
// SDRAM controller slave port: HTRANS/HRESP encodings, owner state enums
// and small decode helpers.
package sdr_ahb_pkg;

    typedef logic [1:0] htrans_t;
    typedef logic [1:0] hresp_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam hresp_t  HRESP_OKAY    = 2'b00;

    // Address-phase ownership: exactly one master always owns the address bus.
    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } addr_own_e;

    // Data-phase ownership: lags address ownership by one accepted transfer.
    typedef enum logic [1:0] {
        D_NONE = 2'b00,
        D0     = 2'b01,
        D1     = 2'b10
    } data_own_e;

    // NONSEQ or SEQ: a real transfer that will have a data phase.
    function automatic logic htrans_active(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

    function automatic data_own_e data_own_of(input addr_own_e o);
        return (o == OWN1) ? D1 : D0;
    endfunction

endpackage

// File: rtl/sdr_ahb_arbiter_if.sv
// sdr_ahb_arbiter_if
// One AHB-Lite link plus the REQ/GNT handshake. Instantiated once per master
// link and once for the controller link.
// Modports:
//   master    - a bus master driving requests (used by the master side)
//   slave     - the arbiter's view of a master link
//   initiator - the arbiter's view of the controller link (drives HSEL/HREADYIN)
//   target    - the controller's view of the controller link
interface sdr_ahb_arbiter_if;
    import sdr_ahb_pkg::*;

    logic        REQ;
    logic        GNT;
    logic        HSEL;
    logic [31:0] HADDR;
    htrans_t     HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADY;
    hresp_t      HRESP;
    logic [31:0] HRDATA;

    modport master (
        output REQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  GNT, HREADY, HRESP, HRDATA
    );

    modport slave (
        input  REQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output GNT, HREADY, HRESP, HRDATA
    );

    modport initiator (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        input  HREADY, HRESP, HRDATA
    );

    modport target (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        output HREADY, HRESP, HRDATA
    );

endinterface

// File: rtl/sdr_ahb_arb_hold.sv
// sdr_ahb_arb_hold
// Hold-time limiter for the current address owner. Counts cycles during which
// the non-owning master is requesting; saturates at MAX_HOLD.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   switch_i        ownership changes at the coming edge (clears the count)
//   other_req_i     REQ of the master that does not own the address bus
//   expired_o       owner has used up its hold budget (never when MAX_HOLD=0)
module sdr_ahb_arb_hold
    import sdr_ahb_pkg::*;
#(
    parameter logic [7:0] MAX_HOLD = 8'd64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic switch_i,
    input  logic other_req_i,
    output logic expired_o
);

    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (switch_i || !other_req_i) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != MAX_HOLD) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign expired_o = (MAX_HOLD != 8'd0) && (hold_cnt_q == MAX_HOLD);

endmodule

// File: rtl/sdr_ahb_arbiter.sv
// sdr_ahb_arbiter
// Two-master AHB-Lite arbiter sharing the SDRAM controller's single slave
// port between M0 (CPU) and M1 (DMA/bridge). Address ownership changes only
// at idle address phases; data-phase ownership is tracked separately so wait
// states and responses go only to the master whose data phase is active.
// Ports:
//   HCLK, HRESETN  clock, asynchronous active-low reset (shared with controller)
//   M0, M1         master links (REQ/GNT + AHB-Lite master signals)
//   S              controller link (HSEL/HADDR/.../HREADYIN out, HREADY/HRESP/HRDATA in)
// Parameters:
//   MAX_HOLD       cycles an owner keeps GNT while the other requests (0 = unlimited)
//   PARK_MASTER    master owning the address bus when nobody requests
// Build option:
//   SDR_AHB_ARB_RR_EN  simultaneous requests go to the master that was not
//                      the most recent transfer owner; otherwise M0 wins ties.
module sdr_ahb_arbiter
    import sdr_ahb_pkg::*;
#(
    parameter logic [7:0] MAX_HOLD    = 8'd64,
    parameter bit         PARK_MASTER = 1'b0
) (
    input  logic                      HCLK,
    input  logic                      HRESETN,
    sdr_ahb_arbiter_if.slave          M0,
    sdr_ahb_arbiter_if.slave          M1,
    sdr_ahb_arbiter_if.initiator      S
);

    localparam addr_own_e PARK_OWN = addr_own_e'(PARK_MASTER);

    addr_own_e addr_owner_q;
    addr_own_e addr_owner_d;
    data_own_e data_owner_q;
    logic [1:0] req_q;
    logic       hold_expired;
    logic       switch_pt;
    logic       owner_req;
    logic       other_req;
    logic       tie;
    logic       tie_win;
    logic [1:0] req;
    htrans_t    own_htrans;

    assign req = {M1.REQ, M0.REQ};

    // ------------------------------------------------------------------
    // Address path: combinational mux from the address owner.
    // ------------------------------------------------------------------
    always_comb begin
        if (addr_owner_q == OWN1) begin
            S.HADDR    = M1.HADDR;
            own_htrans = M1.HTRANS;
            S.HWRITE   = M1.HWRITE;
            S.HSIZE    = M1.HSIZE;
            S.HBURST   = M1.HBURST;
        end else begin
            S.HADDR    = M0.HADDR;
            own_htrans = M0.HTRANS;
            S.HWRITE   = M0.HWRITE;
            S.HSIZE    = M0.HSIZE;
            S.HBURST   = M0.HBURST;
        end
    end

    assign S.HTRANS   = own_htrans;
    assign S.HSEL     = own_htrans[1];
    assign S.HREADYIN = S.HREADY;

    // ------------------------------------------------------------------
    // Data path: write data and responses follow the data-phase owner.
    // ------------------------------------------------------------------
    always_comb begin
        S.HWDATA  = '0;
        M0.HREADY = 1'b1;
        M1.HREADY = 1'b1;
        M0.HRESP  = HRESP_OKAY;
        M1.HRESP  = HRESP_OKAY;
        case (data_owner_q)
            D0: begin
                S.HWDATA  = M0.HWDATA;
                M0.HREADY = S.HREADY;
                M0.HRESP  = S.HRESP;
            end
            D1: begin
                S.HWDATA  = M1.HWDATA;
                M1.HREADY = S.HREADY;
                M1.HRESP  = S.HRESP;
            end
            default: ;
        endcase
    end

    assign M0.HRDATA = S.HRDATA;
    assign M1.HRDATA = S.HRDATA;

    // ------------------------------------------------------------------
    // Ownership decision, evaluated only at idle address phases.
    // ------------------------------------------------------------------
    assign switch_pt = S.HREADY && (own_htrans == HTRANS_IDLE);
    assign owner_req = (addr_owner_q == OWN1) ? req[1] : req[0];
    assign other_req = (addr_owner_q == OWN1) ? req[0] : req[1];
    // Both requests rising together: neither master has a prior claim.
    assign tie       = (&req) && !(|req_q);

`ifdef SDR_AHB_ARB_RR_EN
    logic last_owner_q;
    assign tie_win = ~last_owner_q;
`else
    assign tie_win = 1'b0;
`endif

    always_comb begin
        addr_owner_d = addr_owner_q;
        if (switch_pt) begin
            if (tie) begin
                addr_owner_d = addr_own_e'(tie_win);
            end else if (!owner_req && other_req) begin
                addr_owner_d = addr_own_e'(~addr_owner_q);
            end else if (!owner_req && !other_req) begin
                addr_owner_d = PARK_OWN;
            end else if (other_req && hold_expired) begin
                addr_owner_d = addr_own_e'(~addr_owner_q);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            addr_owner_q <= PARK_OWN;
            data_owner_q <= D_NONE;
            req_q        <= '0;
        end else begin
            addr_owner_q <= addr_owner_d;
            req_q        <= req;
            if (S.HREADY) begin
                data_owner_q <= htrans_active(own_htrans) ? data_own_of(addr_owner_q) : D_NONE;
            end
        end
    end

`ifdef SDR_AHB_ARB_RR_EN
    // Records the master whose address phase was most recently accepted.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            last_owner_q <= 1'b1;
        end else if (S.HREADY && htrans_active(own_htrans)) begin
            last_owner_q <= (addr_owner_q == OWN1);
        end
    end
`endif

    sdr_ahb_arb_hold #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk_i       (HCLK),
        .rst_n_i     (HRESETN),
        .switch_i    (addr_owner_d != addr_owner_q),
        .other_req_i (other_req),
        .expired_o   (hold_expired)
    );

    // GNT drops on expiry; the owner keeps the bus until its next idle phase.
    assign M0.GNT = (addr_owner_q == OWN0) && !hold_expired;
    assign M1.GNT = (addr_owner_q == OWN1) && !hold_expired;

endmodule

// File: tb/tb_sdr_ahb_arbiter.sv
module tb_sdr_ahb_arbiter;
    import sdr_ahb_pkg::*;

    localparam logic [1:0]  TI = HTRANS_IDLE;
    localparam logic [1:0]  TN = HTRANS_NONSEQ;
    localparam logic [1:0]  TS = HTRANS_SEQ;
    localparam logic [31:0] W0 = 32'hB0B0_0000;
    localparam logic [31:0] WD1 = 32'hCAFE_0001;
    localparam logic [31:0] RD = 32'h1234_5678;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] A2 = 32'h0000_0400;

`ifdef SDR_AHB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic HCLK;
    logic HRESETN;
    int   n_checks;
    int   n_errors;

    sdr_ahb_arbiter_if m0_if ();
    sdr_ahb_arbiter_if m1_if ();
    sdr_ahb_arbiter_if s_if ();

    sdr_ahb_arbiter #(
        .MAX_HOLD    (8'd4),
        .PARK_MASTER (1'b0)
    ) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .M0      (m0_if.slave),
        .M1      (m1_if.slave),
        .S       (s_if.initiator)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        m0_req;
        logic [1:0]  m0_trans;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic [1:0]  m1_trans;
        logic [31:0] m1_addr;
        logic        m1_write;
        logic [31:0] m1_wdata;
        logic        s_ready;
        logic [1:0]  s_resp;
        logic        e_gnt0;
        logic        e_gnt1;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic [31:0] e_wdata;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [1:0]  e_resp0;
        logic [1:0]  e_resp1;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        m0_if.REQ    = v.m0_req;
        m0_if.HTRANS = v.m0_trans;
        m0_if.HADDR  = v.m0_addr;
        m1_if.REQ    = v.m1_req;
        m1_if.HTRANS = v.m1_trans;
        m1_if.HADDR  = v.m1_addr;
        m1_if.HWRITE = v.m1_write;
        m1_if.HWDATA = v.m1_wdata;
        s_if.HREADY  = v.s_ready;
        s_if.HRESP   = v.s_resp;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d_gnt0", i),   32'(m0_if.GNT),    32'(v.e_gnt0));
        check($sformatf("v%0d_gnt1", i),   32'(m1_if.GNT),    32'(v.e_gnt1));
        check($sformatf("v%0d_htrans", i), 32'(s_if.HTRANS),  32'(v.e_trans));
        check($sformatf("v%0d_hsel", i),   32'(s_if.HSEL),    32'(v.e_trans[1]));
        check($sformatf("v%0d_haddr", i),  s_if.HADDR,        v.e_addr);
        check($sformatf("v%0d_hwrite", i), 32'(s_if.HWRITE),  32'(v.e_write));
        check($sformatf("v%0d_hwdata", i), s_if.HWDATA,       v.e_wdata);
        check($sformatf("v%0d_rdy0", i),   32'(m0_if.HREADY), 32'(v.e_rdy0));
        check($sformatf("v%0d_rdy1", i),   32'(m1_if.HREADY), 32'(v.e_rdy1));
        check($sformatf("v%0d_resp0", i),  32'(m0_if.HRESP),  32'(v.e_resp0));
        check($sformatf("v%0d_resp1", i),  32'(m1_if.HRESP),  32'(v.e_resp1));
        check($sformatf("v%0d_rdata0", i), m0_if.HRDATA,      RD);
        check($sformatf("v%0d_rdata1", i), m1_if.HRDATA,      RD);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Sequence A: M1 takes the idle bus, one NONSEQ write with a wait state.
        tbl.push_back('{1'b0, TI, 32'h0, 1'b0, TI, A1, 1'b0, WD1, 1'b1, 2'b00,
                        1'b1, 1'b0, TI, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b1, TI, A1, 1'b1, WD1, 1'b1, 2'b00,
                        1'b1, 1'b0, TI, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b1, TN, A1, 1'b1, WD1, 1'b1, 2'b00,
                        1'b0, 1'b1, TN, A1, 1'b1, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b1, TI, A1, 1'b1, WD1, 1'b0, 2'b00,
                        1'b0, 1'b1, TI, A1, 1'b1, WD1, 1'b1, 1'b0, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b1, TI, A1, 1'b1, WD1, 1'b1, 2'b00,
                        1'b0, 1'b1, TI, A1, 1'b1, WD1, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b0, TI, A1, 1'b1, WD1, 1'b1, 2'b00,
                        1'b0, 1'b1, TI, A1, 1'b1, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h0, 1'b0, TI, A1, 1'b0, WD1, 1'b1, 2'b00,
                        1'b1, 1'b0, TI, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        // Sequence B: M0 INCR4 read, 3 wait states, M1 requests mid-burst,
        // hold limit expires, switch at M0's first idle phase.
        tbl.push_back('{1'b1, TI, 32'h200, 1'b0, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b1, 1'b0, TI, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TN, 32'h200, 1'b0, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b1, 1'b0, TN, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h204, 1'b1, TI, A2, 1'b0, 32'h0, 1'b0, 2'b00,
                        1'b1, 1'b0, TS, 32'h204, 1'b0, W0, 1'b0, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h204, 1'b1, TI, A2, 1'b0, 32'h0, 1'b0, 2'b00,
                        1'b1, 1'b0, TS, 32'h204, 1'b0, W0, 1'b0, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h204, 1'b1, TI, A2, 1'b0, 32'h0, 1'b0, 2'b01,
                        1'b1, 1'b0, TS, 32'h204, 1'b0, W0, 1'b0, 1'b1, 2'b01, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h204, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b1, 1'b0, TS, 32'h204, 1'b0, W0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h208, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b0, 1'b0, TS, 32'h208, 1'b0, W0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TS, 32'h20C, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b0, 1'b0, TS, 32'h20C, 1'b0, W0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TI, 32'h20C, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b0, 1'b0, TI, 32'h20C, 1'b0, W0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b1, TI, 32'h20C, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b0, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h20C, 1'b0, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b0, 1'b1, TI, A2, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});
        tbl.push_back('{1'b0, TI, 32'h20C, 1'b0, TI, A2, 1'b0, 32'h0, 1'b1, 2'b00,
                        1'b1, 1'b0, TI, 32'h20C, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00});

        // Static stimulus and unused link signals.
        m0_if.HSEL     = 1'b0;
        m0_if.HREADYIN = 1'b0;
        m0_if.HWRITE   = 1'b0;
        m0_if.HSIZE    = 3'b010;
        m0_if.HBURST   = 3'b011;
        m0_if.HWDATA   = W0;
        m1_if.HSEL     = 1'b0;
        m1_if.HREADYIN = 1'b0;
        m1_if.HSIZE    = 3'b010;
        m1_if.HBURST   = 3'b000;
        s_if.REQ       = 1'b0;
        s_if.GNT       = 1'b0;
        s_if.HRDATA    = RD;
        apply(tbl[0]);

        // Reset state.
        HRESETN = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_gnt0",   32'(m0_if.GNT),    32'd1);
        check("rst_gnt1",   32'(m1_if.GNT),    32'd0);
        check("rst_htrans", 32'(s_if.HTRANS),  32'(TI));
        check("rst_hsel",   32'(s_if.HSEL),    32'd0);
        check("rst_rdy0",   32'(m0_if.HREADY), 32'd1);
        check("rst_rdy1",   32'(m1_if.HREADY), 32'd1);
        check("rst_resp0",  32'(m0_if.HRESP),  32'(HRESP_OKAY));
        check("rst_resp1",  32'(m1_if.HRESP),  32'(HRESP_OKAY));
        @(posedge HCLK);
        #1 HRESETN = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge HCLK);
            check_vec(i, tbl[i]);
            @(posedge HCLK);
            #1;
        end

        // Both requests rise together at an idle point.
        m0_if.REQ = 1'b1;
        m1_if.REQ = 1'b1;
        @(negedge HCLK);
        check("tie_pre_gnt0", 32'(m0_if.GNT), 32'd1);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("tie_gnt0", 32'(m0_if.GNT), 32'(!RR));
        check("tie_gnt1", 32'(m1_if.GNT), 32'(RR));
        m0_if.REQ = 1'b0;
        m1_if.REQ = 1'b0;
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("tie_park_gnt0", 32'(m0_if.GNT), 32'd1);
        check("tie_park_gnt1", 32'(m1_if.GNT), 32'd0);

        // Reset during an M1 write data phase.
        m1_if.REQ = 1'b1;
        @(posedge HCLK);
        #1;
        m1_if.HTRANS = TN;
        m1_if.HADDR  = 32'h300;
        m1_if.HWRITE = 1'b1;
        m1_if.HWDATA = 32'h5555_AAAA;
        @(negedge HCLK);
        check("rw_gnt1",  32'(m1_if.GNT), 32'd1);
        check("rw_haddr", s_if.HADDR,     32'h300);
        @(posedge HCLK);
        #1;
        m1_if.HTRANS = TI;
        s_if.HREADY  = 1'b0;
        @(negedge HCLK);
        check("rw_hwdata", s_if.HWDATA,      32'h5555_AAAA);
        check("rw_rdy1",   32'(m1_if.HREADY), 32'd0);
        #1 HRESETN = 1'b0;
        #1;
        check("rr_hwdata", s_if.HWDATA,       32'h0);
        check("rr_gnt0",   32'(m0_if.GNT),    32'd1);
        check("rr_gnt1",   32'(m1_if.GNT),    32'd0);
        check("rr_rdy1",   32'(m1_if.HREADY), 32'd1);
        check("rr_htrans", 32'(s_if.HTRANS),  32'(TI));
        check("rr_haddr",  s_if.HADDR,        32'h20C);
        m1_if.REQ   = 1'b0;
        s_if.HREADY = 1'b1;
        @(posedge HCLK);
        #1 HRESETN = 1'b1;
        @(negedge HCLK);
        check("post_rst_gnt0", 32'(m0_if.GNT), 32'd1);
        check("post_rst_gnt1", 32'(m1_if.GNT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
